// File: rtl/regfile_2r1w_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2r1w_pkg
// Description : Shared datapath constants for the two-read/one-write register
//               file (default data width, register count and index width).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_2r1w_pkg;

  localparam int RF_WIDTH = 16;
  localparam int RF_NREGS = 8;
  localparam int RF_AW    = 3;

endpackage : regfile_2r1w_pkg
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_port
// Description : One read port of the register file: index mux with range
//               check, optional same-cycle write bypass and optional output
//               register.
// Ports       : clk, reset        - clock and synchronous active-high reset
//               regs              - flattened register array (reg i at i*WIDTH)
//               readnum           - read index
//               write, writenum,
//               data_in           - write port, observed for bypass
//               data_out          - read data (0 for out-of-range index)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int NREGS   = RF_NREGS,
  parameter int AW      = RF_AW,
  parameter int BYPASS  = 1,
  parameter int REG_OUT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREGS*WIDTH-1:0] regs,
  input  logic [AW-1:0]          readnum,
  input  logic                   write,
  input  logic [AW-1:0]          writenum,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out
);

  logic [WIDTH-1:0] rd_val;

  // Indices with no matching register fall through to the zero default,
  // so an out-of-range read is 0 rather than X.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (readnum == AW'(i)) begin
        rd_val = regs[i*WIDTH +: WIDTH];
      end
    end
    // Range check on writenum keeps an ignored out-of-range write from
    // leaking onto an out-of-range read.
    if ((BYPASS != 0) && write && (writenum == readnum) && (int'(writenum) < NREGS)) begin
      rd_val = data_in;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [WIDTH-1:0] dout_d;
      logic [WIDTH-1:0] dout_q;

      always_comb begin
        dout_d = rd_val;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          dout_q <= '0;
        end else begin
          dout_q <= dout_d;
        end
      end

      assign data_out = dout_q;
    end else begin : g_comb_out
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign data_out       = rd_val;
    end
  endgenerate

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2r1w
// Description : Parametrised register file, one write port and two
//               independent read ports, synchronous clear, written-since-
//               reset mask.
// Ports       : clk, reset                 - clock, sync active-high reset
//               write, writenum, data_in   - write port
//               readnum_a, data_out_a      - read port A
//               readnum_b, data_out_b      - read port B
//               written                    - bit i set once reg i is written
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int NREGS   = RF_NREGS,
  parameter int AW      = RF_AW,
  parameter int BYPASS  = 1,
  parameter int REG_OUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [AW-1:0]    writenum,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  output logic [NREGS-1:0] written
);

  logic [NREGS*WIDTH-1:0] regs_d;
  logic [NREGS*WIDTH-1:0] regs_q;
  logic [NREGS-1:0]       written_d;
  logic [NREGS-1:0]       written_q;
  logic [NREGS-1:0]       wr_sel;

  // One-hot write decode; an out-of-range writenum matches no bit, which
  // makes such a write a no-op for both the array and the mask.
  always_comb begin
    wr_sel    = '0;
    regs_d    = regs_q;
    for (int i = 0; i < NREGS; i++) begin
      wr_sel[i] = write && (writenum == AW'(i));
      if (wr_sel[i]) begin
        regs_d[i*WIDTH +: WIDTH] = data_in;
      end
    end
    written_d = written_q | wr_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q    <= '0;
      written_q <= '0;
    end else begin
      regs_q    <= regs_d;
      written_q <= written_d;
    end
  end

  assign written = written_q;

  regfile_read_port #(
    .WIDTH   (WIDTH),
    .NREGS   (NREGS),
    .AW      (AW),
    .BYPASS  (BYPASS),
    .REG_OUT (REG_OUT)
  ) u_read_a (
    .clk      (clk),
    .reset    (reset),
    .regs     (regs_q),
    .readnum  (readnum_a),
    .write    (write),
    .writenum (writenum),
    .data_in  (data_in),
    .data_out (data_out_a)
  );

  regfile_read_port #(
    .WIDTH   (WIDTH),
    .NREGS   (NREGS),
    .AW      (AW),
    .BYPASS  (BYPASS),
    .REG_OUT (REG_OUT)
  ) u_read_b (
    .clk      (clk),
    .reset    (reset),
    .regs     (regs_q),
    .readnum  (readnum_b),
    .write    (write),
    .writenum (writenum),
    .data_in  (data_in),
    .data_out (data_out_b)
  );

endmodule : regfile_2r1w
`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_2r1w
// Description : Self-checking bench for regfile_2r1w. Four configurations
//               share one stimulus stream:
//                 u_byp  : NREGS=8, BYPASS=1, REG_OUT=0
//                 u_nob  : NREGS=8, BYPASS=0, REG_OUT=0
//                 u_reg  : NREGS=8, BYPASS=1, REG_OUT=1
//                 u_six  : NREGS=6, BYPASS=1, REG_OUT=0
//               A plain array model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_2r1w;

  logic        clk;
  logic        reset;
  logic        write;
  logic [2:0]  writenum;
  logic [15:0] data_in;
  logic [2:0]  readnum_a;
  logic [2:0]  readnum_b;

  logic [15:0] byp_a, byp_b, nob_a, nob_b, reg_a, reg_b, six_a, six_b;
  logic [7:0]  byp_w, nob_w, reg_w;
  logic [5:0]  six_w;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] mem8 [8];
  logic [15:0] mem6 [6];
  logic [7:0]  wr8;
  logic [5:0]  wr6;
  logic [15:0] regq_a, regq_b;
  bit          model_valid = 0;

  regfile_2r1w #(.WIDTH(16), .NREGS(8), .AW(3), .BYPASS(1), .REG_OUT(0)) u_byp (
    .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
    .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(byp_a), .data_out_b(byp_b), .written(byp_w));

  regfile_2r1w #(.WIDTH(16), .NREGS(8), .AW(3), .BYPASS(0), .REG_OUT(0)) u_nob (
    .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
    .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(nob_a), .data_out_b(nob_b), .written(nob_w));

  regfile_2r1w #(.WIDTH(16), .NREGS(8), .AW(3), .BYPASS(1), .REG_OUT(1)) u_reg (
    .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
    .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(reg_a), .data_out_b(reg_b), .written(reg_w));

  regfile_2r1w #(.WIDTH(16), .NREGS(6), .AW(3), .BYPASS(1), .REG_OUT(0)) u_six (
    .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
    .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(six_a), .data_out_b(six_b), .written(six_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // What a combinational read port shows in the current cycle.
  function automatic logic [15:0] exp_rd(input int idx, input int nregs, input bit byp);
    if (idx >= nregs) return 16'h0000;
    if (byp && write && (int'(writenum) == idx)) return data_in;
    if (nregs == 6) return mem6[idx];
    return mem8[idx];
  endfunction

  // Drive one cycle, check all outputs just before the edge, advance model.
  task automatic cycle(input bit rst, input bit w, input int wn, input logic [15:0] din,
                       input int ra, input int rb);
    logic [15:0] na, nb;
    @(negedge clk);
    reset     = rst;
    write     = w;
    writenum  = 3'(wn);
    data_in   = din;
    readnum_a = 3'(ra);
    readnum_b = 3'(rb);
    #3;
    if (model_valid) begin
      check_eq("byp_a", 32'(byp_a), 32'(exp_rd(ra, 8, 1)));
      check_eq("byp_b", 32'(byp_b), 32'(exp_rd(rb, 8, 1)));
      check_eq("nob_a", 32'(nob_a), 32'(exp_rd(ra, 8, 0)));
      check_eq("nob_b", 32'(nob_b), 32'(exp_rd(rb, 8, 0)));
      check_eq("reg_a", 32'(reg_a), 32'(regq_a));
      check_eq("reg_b", 32'(reg_b), 32'(regq_b));
      check_eq("six_a", 32'(six_a), 32'(exp_rd(ra, 6, 1)));
      check_eq("six_b", 32'(six_b), 32'(exp_rd(rb, 6, 1)));
      check_eq("byp_written", 32'(byp_w), 32'(wr8));
      check_eq("nob_written", 32'(nob_w), 32'(wr8));
      check_eq("reg_written", 32'(reg_w), 32'(wr8));
      check_eq("six_written", 32'(six_w), 32'(wr6));
    end
    na = exp_rd(ra, 8, 1);
    nb = exp_rd(rb, 8, 1);
    if (rst) begin
      for (int i = 0; i < 8; i++) mem8[i] = '0;
      for (int i = 0; i < 6; i++) mem6[i] = '0;
      wr8 = '0; wr6 = '0;
      regq_a = '0; regq_b = '0;
      model_valid = 1;
    end else begin
      regq_a = na;
      regq_b = nb;
      if (w && wn < 8) begin mem8[wn] = din; wr8[wn] = 1'b1; end
      if (w && wn < 6) begin mem6[wn] = din; wr6[wn] = 1'b1; end
    end
  endtask

  initial begin
    reset = 1'b0; write = 1'b0; writenum = '0; data_in = '0;
    readnum_a = '0; readnum_b = '0;
    wr8 = '0; wr6 = '0; regq_a = '0; regq_b = '0;

    // Reset, then sweep every index on both ports
    cycle(1, 0, 0, 16'h0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 16'h0, i, 7 - i);
      check_eq("rst_zero_a", 32'(byp_a), 32'h0);
      check_eq("rst_zero_b", 32'(byp_b), 32'h0);
    end
    check_eq("rst_written", 32'(byp_w), 32'h00);

    // Basic write/read
    cycle(0, 1, 3, 16'hBEEF, 0, 0);
    cycle(0, 0, 0, 16'h0, 3, 0);
    check_eq("tp_beef_a", 32'(byp_a), 32'hBEEF);
    check_eq("tp_beef_b", 32'(byp_b), 32'h0000);
    check_eq("tp_written08", 32'(byp_w), 32'h08);

    // Bypass vs no bypass
    cycle(0, 1, 5, 16'h1111, 0, 0);
    cycle(0, 1, 5, 16'h2222, 5, 5);
    check_eq("tp_bypass", 32'(byp_a), 32'h2222);
    check_eq("tp_nobypass", 32'(nob_a), 32'h1111);

    // Registered mode: old value this cycle, new value one edge later
    cycle(0, 1, 2, 16'h00AA, 0, 0);
    cycle(0, 0, 0, 16'h0, 2, 0);
    check_eq("tp_regout_prev", 32'(reg_a), 32'h0000);
    cycle(0, 0, 0, 16'h0, 2, 0);
    check_eq("tp_regout_new", 32'(reg_a), 32'h00AA);

    // Reset priority, range handling on the 6-register instance
    cycle(0, 1, 1, 16'h5555, 0, 0);
    cycle(1, 1, 1, 16'h7777, 0, 0);
    cycle(0, 1, 7, 16'h9999, 1, 6);
    check_eq("tp_rstprio_r1", 32'(six_a), 32'h0);
    check_eq("tp_rstprio_w", 32'(six_w), 32'h0);
    check_eq("tp_oor_read", 32'(six_b), 32'h0);
    check_eq("tp_reg_after_rst", 32'(reg_a), 32'h0);
    cycle(0, 0, 0, 16'h0, 7, 6);
    check_eq("tp_oor_write6", 32'(six_w), 32'h0);
    check_eq("tp_oor_read_a", 32'(six_a), 32'h0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 39) == 0),
            ($urandom_range(0, 2) != 0),
            int'($urandom_range(0, 7)),
            16'($urandom()),
            int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)));
    end
    cycle(0, 0, 0, 16'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_2r1w
`default_nettype wire
